keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500, meaning clocks per column step (4 kHz column rate, 1 kHz frame rate at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 20, meaning consecutive identical frames required to accept a press or a release (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: sole system clock (50 MHz board clock), all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port row_n, input, 4 bits: keypad rows, active-low, asynchronous to clk, externally pulled up.
REQ-006 SHALL have port col_n, output, 4 bits: keypad column strobes, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_valid, output, 1 bit: one-cycle pulse on each accepted press.
REQ-008 SHALL have port key_code, output, 4 bits: code of the last accepted key, held between presses.
REQ-009 SHALL have port key_held, output, 1 bit: high from an accepted press until its accepted release.
REQ-010 SHALL have port digits, output, 16 bits: last four accepted codes, [15:12] oldest and [3:0] newest; wires directly to the four 4-bit digit inputs of the display path.

Function
REQ-011 SHALL pass row_n through a two-flop synchronizer before any use.
REQ-012 SHALL advance the column index 0->1->2->3->0 every SCAN_DIV clocks and drive col_n low only at bit [index].
REQ-013 SHALL sample the synchronized rows on the last clock of each column period.
REQ-014 SHALL mark a key at (row r, column c) pressed when synchronized row bit r is 0 during column c's sample.
REQ-015 SHALL define a frame as columns 0..3, ending on the last clock of column 3.
REQ-016 SHALL classify each frame as NONE (0 keys), SINGLE (exactly 1 key) or MULTI (2 or more keys).
REQ-017 SHALL encode a SINGLE key as code = 4*r + c, range 0x0..0xF.
REQ-018 SHALL implement FSM states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-019 SHALL use the following IDLE transition: a SINGLE frame latches the candidate code, sets the frame count to 1 and goes to PRESS_CHK; NONE and MULTI stay in IDLE.
REQ-020 SHALL use the following PRESS_CHK transition: a SINGLE frame with the same code increments the count; a SINGLE frame with a different code re-latches the candidate and sets the count to 1; NONE or MULTI returns to IDLE.
REQ-021 SHALL accept a press when the count reaches DEBOUNCE_FRAMES; at the clock after that frame end it SHALL pulse key_valid for exactly 1 cycle, load key_code, set key_held, shift digits as {digits[11:0], code} and enter HELD.
REQ-022 SHALL use the following HELD transition: a NONE frame sets the count to 1 and goes to REL_CHK; SINGLE or MULTI frames stay in HELD with no new events (no auto-repeat, and a second key while held is ignored).
REQ-023 SHALL use the following REL_CHK transition: a NONE frame increments the count; any non-NONE frame returns to HELD; when the count reaches DEBOUNCE_FRAMES it SHALL clear key_held and go to IDLE.
REQ-024 SHALL, when DEBOUNCE_FRAMES=1, accept a press at the end of the first SINGLE frame and a release at the end of the first NONE frame.
REQ-025 SHALL shift out the oldest digit silently when digits is full (5th and later presses); no overflow flag exists.
REQ-026 SHALL size counters to hold SCAN_DIV-1 and DEBOUNCE_FRAMES without wrap.

Reset
REQ-027 SHALL, while reset is high, force col_n=4'b1110, key_valid=0, key_code=0, key_held=0, digits=16'h0000, state IDLE, and all counters and synchronizer flops to 0 (synchronizer flops to 1).
REQ-028 SHALL restart scanning at column 0 after reset deasserts; a key held through reset is re-detected as a new press after DEBOUNCE_FRAMES frames.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2; 16-clock frames)
REQ-029 SHALL verify reset: after reset, col_n=1110 and all outputs are 0; col_n=1101 after 4 clocks and 1110 again after 16 clocks.
REQ-030 SHALL verify a steady press: key (r2,c1) held for 5 frames gives exactly one key_valid pulse, key_code=9, digits=16'h0009, key_held=1; after release key_held=0 within 2 frames plus 1 clock.
REQ-031 SHALL verify the digit shift: keys 1,2,3,4,5 pressed and released in turn give digits=16'h2345 and five key_valid pulses in total.
REQ-032 SHALL verify bounce rejection: a press lasting less than 1 frame, or toggling every frame, gives no key_valid and digits unchanged.
REQ-033 SHALL verify multi-key handling: (r0,c0) and (r1,c1) pressed together give no event; when (r0,c0) is released with (r1,c1) held steady, one event follows with key_code=5.
REQ-034 SHALL verify reset mid-hold: asserting reset in HELD clears all outputs immediately; with the key still held, a new key_valid fires 2 frames after scanning restarts.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-frame debounce.
// Columns are strobed low one at a time; the synchronized rows are sampled
// at the end of every column period and one 16-key snapshot is formed per
// frame. A four-state FSM debounces presses and releases over whole frames
// and keeps a four-digit history of accepted key codes.
module keypad_scanner #(
    parameter int SCAN_DIV        = 12500,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int                 DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [8:0]         DEB_TARGET = 9'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } frame_cls_t;

    // Number of pressed keys collapsed to none / exactly one / several.
    function automatic frame_cls_t classify(input logic [15:0] keys);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(keys[i]);
        end
        if (n == 5'd0) begin
            return CLS_NONE;
        end else if (n == 5'd1) begin
            return CLS_SINGLE;
        end else begin
            return CLS_MULTI;
        end
    endfunction

    // Bit index of the pressed key equals its code (4*row + column).
    function automatic logic [3:0] encode(input logic [15:0] keys);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                code = 4'(i);
            end
        end
        return code;
    endfunction

    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_col_n;
    logic [15:0]      r_keys;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [7:0]       r_cnt;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic             r_key_held;
    logic [15:0]      r_digits;

    logic             w_col_end;
    logic             w_frame_end;
    logic [1:0]       w_col_next;
    logic [15:0]      w_sample_keys;
    frame_cls_t       w_cls;
    logic [3:0]       w_code;
    logic [8:0]       w_cnt_inc;

    assign w_col_end   = (r_div == DIV_LAST);
    assign w_frame_end = w_col_end && (r_col == 2'd3);
    assign w_col_next  = r_col + 2'd1;
    assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
    assign w_cls       = classify(w_sample_keys);
    assign w_code      = encode(w_sample_keys);

    assign col_n     = r_col_n;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;
    assign digits    = r_digits;

    // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_s1 <= 4'b1111;
            r_row_s2 <= 4'b1111;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    // Snapshot = stored columns with the active column's bits replaced by the live sample.
    always_comb begin
        w_sample_keys = r_keys;
        for (int r = 0; r < 4; r++) begin
            w_sample_keys[4*r + int'(r_col)] = ~r_row_s2[r];
        end
    end

    // Column divider, column strobe and per-column key capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
            r_keys  <= 16'h0000;
        end else if (w_col_end) begin
            r_div   <= '0;
            r_col   <= w_col_next;
            r_col_n <= ~(4'b0001 << w_col_next);
            r_keys  <= w_sample_keys;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Debounce FSM; all key outputs are registered here and change only after a frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= 8'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_held  <= 1'b0;
            r_digits    <= 16'h0000;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cls == CLS_SINGLE) begin
                            r_cand <= w_code;
                            if (DEB_TARGET <= 9'd1) begin
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_code;
                                r_key_held  <= 1'b1;
                                r_digits    <= {r_digits[11:0], w_code};
                                r_cnt       <= 8'd0;
                                r_state     <= ST_HELD;
                            end else begin
                                r_cnt   <= 8'd1;
                                r_state <= ST_PRESS_CHK;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (w_cls != CLS_SINGLE) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_IDLE;
                        end else if (w_code != r_cand) begin
                            // A different single key restarts the count on the new candidate.
                            r_cand <= w_code;
                            r_cnt  <= 8'd1;
                        end else if (w_cnt_inc >= DEB_TARGET) begin
                            r_key_valid <= 1'b1;
                            r_key_code  <= r_cand;
                            r_key_held  <= 1'b1;
                            r_digits    <= {r_digits[11:0], r_cand};
                            r_cnt       <= 8'd0;
                            r_state     <= ST_HELD;
                        end else begin
                            r_cnt <= w_cnt_inc[7:0];
                        end
                    end
                    ST_HELD: begin
                        // Any key activity while held is ignored: no repeat, no second key.
                        if (w_cls == CLS_NONE) begin
                            if (DEB_TARGET <= 9'd1) begin
                                r_key_held <= 1'b0;
                                r_cnt      <= 8'd0;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_cnt   <= 8'd1;
                                r_state <= ST_REL_CHK;
                            end
                        end else begin
                            r_state <= ST_HELD;
                        end
                    end
                    ST_REL_CHK: begin
                        if (w_cls != CLS_NONE) begin
                            r_cnt   <= 8'd0;
                            r_state <= ST_HELD;
                        end else if (w_cnt_inc >= DEB_TARGET) begin
                            r_key_held <= 1'b0;
                            r_cnt      <= 8'd0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc[7:0];
                        end
                    end
                    default: begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end else begin
                r_state <= r_state;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (16-clock frames).
// A behavioural keypad matrix turns a 16-bit pressed-key mask into row_n.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] digits;

    logic [15:0] key_mask;
    int          n_cmp;
    int          n_fail;
    int          n_pulses;

    typedef struct {
        logic [15:0] mask;
        int          frames;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic        exp_held;
        logic [15:0] exp_digits;
    } vec_t;

    vec_t vecs[33];

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always @* begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[4*r + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    // Count every clock cycle in which key_valid is high.
    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1) n_pulses = n_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        n_pulses = 0;
        key_mask = 16'h0000;
        reset    = 1'b1;

        vecs[0]  = '{16'h0200, 5, 1, 4'h9, 1'b1, 16'h0009};
        vecs[1]  = '{16'h0000, 1, 1, 4'h9, 1'b1, 16'h0009};
        vecs[2]  = '{16'h0000, 1, 1, 4'h9, 1'b0, 16'h0009};
        vecs[3]  = '{16'h0002, 2, 2, 4'h1, 1'b1, 16'h0091};
        vecs[4]  = '{16'h0000, 2, 2, 4'h1, 1'b0, 16'h0091};
        vecs[5]  = '{16'h0004, 2, 3, 4'h2, 1'b1, 16'h0912};
        vecs[6]  = '{16'h0000, 2, 3, 4'h2, 1'b0, 16'h0912};
        vecs[7]  = '{16'h0008, 2, 4, 4'h3, 1'b1, 16'h9123};
        vecs[8]  = '{16'h0000, 2, 4, 4'h3, 1'b0, 16'h9123};
        vecs[9]  = '{16'h0010, 2, 5, 4'h4, 1'b1, 16'h1234};
        vecs[10] = '{16'h0000, 2, 5, 4'h4, 1'b0, 16'h1234};
        vecs[11] = '{16'h0020, 2, 6, 4'h5, 1'b1, 16'h2345};
        vecs[12] = '{16'h0000, 2, 6, 4'h5, 1'b0, 16'h2345};
        vecs[13] = '{16'h0080, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[14] = '{16'h0000, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[15] = '{16'h0080, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[16] = '{16'h0000, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[17] = '{16'h0080, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[18] = '{16'h0000, 1, 6, 4'h5, 1'b0, 16'h2345};
        vecs[19] = '{16'h0021, 3, 6, 4'h5, 1'b0, 16'h2345};
        vecs[20] = '{16'h0020, 2, 7, 4'h5, 1'b1, 16'h3455};
        vecs[21] = '{16'h0028, 3, 7, 4'h5, 1'b1, 16'h3455};
        vecs[22] = '{16'h0008, 2, 7, 4'h5, 1'b1, 16'h3455};
        vecs[23] = '{16'h0000, 2, 7, 4'h5, 1'b0, 16'h3455};
        vecs[24] = '{16'h0400, 1, 7, 4'h5, 1'b0, 16'h3455};
        vecs[25] = '{16'h0800, 1, 7, 4'h5, 1'b0, 16'h3455};
        vecs[26] = '{16'h0800, 1, 8, 4'hB, 1'b1, 16'h455B};
        vecs[27] = '{16'h0000, 2, 8, 4'hB, 1'b0, 16'h455B};
        vecs[28] = '{16'h8000, 2, 9, 4'hF, 1'b1, 16'h55BF};
        vecs[29] = '{16'h0000, 1, 9, 4'hF, 1'b1, 16'h55BF};
        vecs[30] = '{16'h8000, 1, 9, 4'hF, 1'b1, 16'h55BF};
        vecs[31] = '{16'h0000, 1, 9, 4'hF, 1'b1, 16'h55BF};
        vecs[32] = '{16'h0000, 1, 9, 4'hF, 1'b0, 16'h55BF};

        // Reset state and column stepping.
        step(3);
        check("rst col_n", 32'(col_n), 32'h0000000E);
        check("rst key_valid", 32'(key_valid), 32'h0);
        check("rst key_code", 32'(key_code), 32'h0);
        check("rst key_held", 32'(key_held), 32'h0);
        check("rst digits", 32'(digits), 32'h0);
        reset = 1'b0;
        step(4);
        check("col1 col_n", 32'(col_n), 32'h0000000D);
        step(12);
        check("wrap col_n", 32'(col_n), 32'h0000000E);

        // Frame-aligned table of key patterns.
        for (int i = 0; i < 33; i++) begin
            key_mask = vecs[i].mask;
            step(16 * vecs[i].frames);
            check($sformatf("vec%0d pulses", i), 32'(n_pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d key_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            check($sformatf("vec%0d key_held", i), 32'(key_held), 32'(vecs[i].exp_held));
            check($sformatf("vec%0d digits", i), 32'(digits), 32'(vecs[i].exp_digits));
        end

        // Press shorter than one frame (seen only in one column-3 sample).
        step(8);
        key_mask = 16'h0080;
        step(8);
        key_mask = 16'h0000;
        step(48);
        check("short pulses", 32'(n_pulses), 32'd9);
        check("short digits", 32'(digits), 32'h000055BF);
        check("short key_held", 32'(key_held), 32'h0);

        // Reset while a key is held, key kept down through and after reset.
        key_mask = 16'h0004;
        step(48);
        check("hold pulses", 32'(n_pulses), 32'd10);
        check("hold key_held", 32'(key_held), 32'h1);
        check("hold digits", 32'(digits), 32'h00005BF2);
        reset = 1'b1;
        #1;
        check("midrst col_n", 32'(col_n), 32'h0000000E);
        check("midrst key_held", 32'(key_held), 32'h0);
        check("midrst key_code", 32'(key_code), 32'h0);
        check("midrst digits", 32'(digits), 32'h0);
        check("midrst key_valid", 32'(key_valid), 32'h0);
        step(3);
        reset = 1'b0;
        step(31);
        check("rearm early key_valid", 32'(key_valid), 32'h0);
        check("rearm early pulses", 32'(n_pulses), 32'd10);
        step(1);
        check("rearm key_valid", 32'(key_valid), 32'h1);
        check("rearm pulses", 32'(n_pulses), 32'd11);
        check("rearm key_code", 32'(key_code), 32'h2);
        check("rearm digits", 32'(digits), 32'h00000002);
        check("rearm key_held", 32'(key_held), 32'h1);
        step(16);
        check("rearm single pulse", 32'(n_pulses), 32'd11);
        check("rearm valid low", 32'(key_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
